// File: rtl/motor_ramp_ctrl.sv
// Dual-channel H-bridge PWM controller with per-period duty ramping and a
// ramp-down / dead-time sequence whenever a channel reverses direction.
module motor_ramp_ctrl #(
    parameter int CLK_DIV      = 10,
    parameter int PWM_PERIOD   = 100,
    parameter int RAMP_STEP    = 5,
    parameter int DEAD_PERIODS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_dir_a,
    input  logic       cmd_dir_b,
    input  logic [6:0] cmd_duty_a,
    input  logic [6:0] cmd_duty_b,
    output logic       A1_A,
    output logic       A1_B,
    output logic       B1_A,
    output logic       B1_B,
    output logic       busy
);

    localparam int PW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DCW = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;

    localparam logic [PW-1:0]  PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [6:0]     PERIOD_V   = 7'(PWM_PERIOD);
    localparam logic [6:0]     CNT_LAST   = 7'(PWM_PERIOD - 1);
    localparam logic [6:0]     STEP_V     = 7'(RAMP_STEP);
    localparam logic [DCW-1:0] DEAD_LAST  = DCW'(DEAD_PERIODS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_RAMPDOWN,
        ST_DEAD
    } state_t;

    logic [PW-1:0] presc_reg;
    logic [6:0]    cnt_reg;
    logic          tick;
    logic          boundary;
    logic          accept;

    logic [1:0]      cmd_dir_arr;
    logic [1:0][6:0] cmd_tgt_arr;
    logic [1:0]      leg_a;
    logic [1:0]      leg_b;
    logic [1:0]      ch_hold;
    logic [1:0]      ch_busy;

    function automatic logic [6:0] clamp_duty(input logic [6:0] d);
        return (d > PERIOD_V) ? PERIOD_V : d;
    endfunction

    function automatic logic [6:0] ramp_toward(input logic [6:0] cur, input logic [6:0] tgt);
        logic [6:0] res;
        res = cur;
        if (cur < tgt) begin
            res = ((tgt - cur) > STEP_V) ? (cur + STEP_V) : tgt;
        end else if (cur > tgt) begin
            res = ((cur - tgt) > STEP_V) ? (cur - STEP_V) : tgt;
        end
        return res;
    endfunction

    function automatic logic [6:0] ramp_down(input logic [6:0] cur);
        return (cur > STEP_V) ? (cur - STEP_V) : 7'd0;
    endfunction

    assign tick     = (presc_reg == PRESC_LAST);
    assign boundary = tick && (cnt_reg == CNT_LAST);
    assign accept   = cmd_valid && cmd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_reg <= '0;
            cnt_reg   <= 7'd0;
        end else begin
            presc_reg <= tick ? '0 : presc_reg + 1'b1;
            if (tick) begin
                cnt_reg <= (cnt_reg == CNT_LAST) ? 7'd0 : cnt_reg + 7'd1;
            end
        end
    end

    assign cmd_dir_arr[0] = cmd_dir_a;
    assign cmd_dir_arr[1] = cmd_dir_b;
    assign cmd_tgt_arr[0] = clamp_duty(cmd_duty_a);
    assign cmd_tgt_arr[1] = clamp_duty(cmd_duty_b);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ch
            state_t           state_reg,       state_next;
            logic [6:0]       duty_reg,        duty_next;
            logic [6:0]       target_reg,      target_next;
            logic             dir_reg,         dir_next;
            logic             pend_dir_reg,    pend_dir_next;
            logic [6:0]       pend_target_reg, pend_target_next;
            logic [DCW-1:0]   dead_cnt_reg,    dead_cnt_next;
            logic             pwm;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_reg       <= ST_IDLE;
                    duty_reg        <= 7'd0;
                    target_reg      <= 7'd0;
                    dir_reg         <= 1'b0;
                    pend_dir_reg    <= 1'b0;
                    pend_target_reg <= 7'd0;
                    dead_cnt_reg    <= '0;
                end else begin
                    state_reg       <= state_next;
                    duty_reg        <= duty_next;
                    target_reg      <= target_next;
                    dir_reg         <= dir_next;
                    pend_dir_reg    <= pend_dir_next;
                    pend_target_reg <= pend_target_next;
                    dead_cnt_reg    <= dead_cnt_next;
                end
            end

            // Commands are only accepted in IDLE/RUN; a command landing on a
            // boundary takes that boundary's step toward its own target.
            always_comb begin
                state_next       = state_reg;
                duty_next        = duty_reg;
                target_next      = target_reg;
                dir_next         = dir_reg;
                pend_dir_next    = pend_dir_reg;
                pend_target_next = pend_target_reg;
                dead_cnt_next    = dead_cnt_reg;
                if (accept) begin
                    if ((cmd_dir_arr[gi] == dir_reg) || (duty_reg == 7'd0)) begin
                        dir_next    = cmd_dir_arr[gi];
                        target_next = cmd_tgt_arr[gi];
                        if (boundary) begin
                            duty_next = ramp_toward(duty_reg, cmd_tgt_arr[gi]);
                        end
                        state_next = ((duty_next == 7'd0) && (cmd_tgt_arr[gi] == 7'd0)) ? ST_IDLE : ST_RUN;
                    end else begin
                        pend_dir_next    = cmd_dir_arr[gi];
                        pend_target_next = cmd_tgt_arr[gi];
                        state_next       = ST_RAMPDOWN;
                        if (boundary) begin
                            duty_next = ramp_down(duty_reg);
                            if (duty_next == 7'd0) begin
                                state_next    = ST_DEAD;
                                dead_cnt_next = '0;
                            end
                        end
                    end
                end else if (boundary) begin
                    case (state_reg)
                        ST_RUN: begin
                            duty_next = ramp_toward(duty_reg, target_reg);
                            if ((duty_next == 7'd0) && (target_reg == 7'd0)) begin
                                state_next = ST_IDLE;
                            end
                        end
                        ST_RAMPDOWN: begin
                            duty_next = ramp_down(duty_reg);
                            if (duty_next == 7'd0) begin
                                state_next    = ST_DEAD;
                                dead_cnt_next = '0;
                            end
                        end
                        ST_DEAD: begin
                            if (dead_cnt_reg == DEAD_LAST) begin
                                dir_next    = pend_dir_reg;
                                target_next = pend_target_reg;
                                duty_next   = ramp_toward(7'd0, pend_target_reg);
                                state_next  = (pend_target_reg == 7'd0) ? ST_IDLE : ST_RUN;
                            end else begin
                                dead_cnt_next = dead_cnt_reg + 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            // Only one leg ever carries PWM; the other is held low.
            always_comb begin
                pwm         = (cnt_reg < duty_reg) && (state_reg != ST_DEAD);
                leg_a[gi]   = dir_reg & pwm;
                leg_b[gi]   = ~dir_reg & pwm;
                ch_hold[gi] = (state_reg == ST_RAMPDOWN) || (state_reg == ST_DEAD);
                ch_busy[gi] = ch_hold[gi] || (duty_reg != target_reg);
            end
        end
    endgenerate

    assign cmd_ready = ~|ch_hold;
    assign busy      = |ch_busy;
    assign A1_A      = leg_a[0];
    assign A1_B      = leg_b[0];
    assign B1_A      = leg_a[1];
    assign B1_B      = leg_b[1];

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Directed bench for motor_ramp_ctrl with a 2-clk tick and a 100-tick period
// (200 clk per period, so a leg at duty d is high for 2*d clk per period).
module tb_motor_ramp_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_dir_a = 1'b0;
    logic       cmd_dir_b = 1'b0;
    logic [6:0] cmd_duty_a = 7'd0;
    logic [6:0] cmd_duty_b = 7'd0;
    logic       A1_A, A1_B, B1_A, B1_B, busy;

    int total = 0;
    int bad   = 0;
    int n_aa, n_ab, n_ba, n_bb, n_rdy_lo, n_busy;
    int n_shoot = 0;
    int n_acc   = 0;
    bit hold_valid = 1'b0;

    motor_ramp_ctrl #(
        .CLK_DIV     (2),
        .PWM_PERIOD  (100),
        .RAMP_STEP   (5),
        .DEAD_PERIODS(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dir_a (cmd_dir_a),
        .cmd_dir_b (cmd_dir_b),
        .cmd_duty_a(cmd_duty_a),
        .cmd_duty_b(cmd_duty_b),
        .A1_A      (A1_A),
        .A1_B      (A1_B),
        .B1_A      (B1_A),
        .B1_B      (B1_B),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Samples at each falling edge; a held command is dropped once it handshakes.
    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            bit take;
            n_aa += int'(A1_A);
            n_ab += int'(A1_B);
            n_ba += int'(B1_A);
            n_bb += int'(B1_B);
            if (A1_A && A1_B) n_shoot++;
            if (B1_A && B1_B) n_shoot++;
            if (!cmd_ready) n_rdy_lo++;
            if (busy) n_busy++;
            take = cmd_valid && cmd_ready;
            if (take) n_acc++;
            @(negedge clk);
            if (take || !hold_valid) cmd_valid = 1'b0;
        end
    endtask

    task automatic clear_acc();
        n_aa = 0; n_ab = 0; n_ba = 0; n_bb = 0; n_rdy_lo = 0; n_busy = 0;
    endtask

    task automatic run_period();
        clear_acc();
        run_cycles(200);
    endtask

    task automatic cmd(input bit da, input int ta, input bit db, input int tb);
        cmd_dir_a  = da;
        cmd_duty_a = 7'(ta);
        cmd_dir_b  = db;
        cmd_duty_b = 7'(tb);
        cmd_valid  = 1'b1;
    endtask

    task automatic check_in_reset(input string tag);
        check({tag, "_a1a"}, int'(A1_A), 0);
        check({tag, "_a1b"}, int'(A1_B), 0);
        check({tag, "_b1a"}, int'(B1_A), 0);
        check({tag, "_b1b"}, int'(B1_B), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_ready"}, int'(cmd_ready), 1);
    endtask

    task automatic idle_periods(input string tag);
        for (int p = 0; p < 5; p++) begin
            run_period();
            check($sformatf("%s_legs_%0d", tag, p), n_aa + n_ab + n_ba + n_bb, 0);
            check($sformatf("%s_rdy_lo_%0d", tag, p), n_rdy_lo, 0);
            check($sformatf("%s_busy_%0d", tag, p), n_busy, 0);
        end
    endtask

    initial begin
        // Reset state and quiet operation after release
        repeat (3) @(negedge clk);
        check_in_reset("rst");
        rst_n = 1'b1;
        idle_periods("idle");

        // A forward 70: ramps 5..70 over 14 boundaries
        cmd(1'b0, 70, 1'b0, 0);
        run_period();
        check("up_p0_a1b", n_ab, 0);
        check("up_p0_busy", n_busy, 199);
        for (int j = 1; j <= 14; j++) begin
            run_period();
            check($sformatf("up_a1b_%0d", j), n_ab, 10 * j);
            check($sformatf("up_a1a_%0d", j), n_aa, 0);
            check($sformatf("up_busy_%0d", j), n_busy, (j < 14) ? 200 : 0);
        end
        run_period();
        check("up_hold_a1b", n_ab, 140);
        check("up_hold_busy", n_busy, 0);

        // Reverse to 30: 14 ramp-down periods, 2 dead, 6 ramp-up
        cmd(1'b1, 30, 1'b0, 0);
        run_period();
        check("rev_p0_a1b", n_ab, 140);
        check("rev_p0_rdy_lo", n_rdy_lo, 199);
        for (int k = 1; k <= 21; k++) begin
            run_period();
            if (k <= 13) begin
                check($sformatf("rev_dn_a1b_%0d", k), n_ab, 140 - 10 * k);
                check($sformatf("rev_dn_a1a_%0d", k), n_aa, 0);
                check($sformatf("rev_dn_rdy_%0d", k), n_rdy_lo, 200);
            end else if (k <= 15) begin
                check($sformatf("rev_dead_legs_%0d", k), n_aa + n_ab, 0);
                check($sformatf("rev_dead_rdy_%0d", k), n_rdy_lo, 200);
            end else begin
                check($sformatf("rev_up_a1a_%0d", k), n_aa, 10 * (k - 15));
                check($sformatf("rev_up_a1b_%0d", k), n_ab, 0);
                check($sformatf("rev_up_rdy_%0d", k), n_rdy_lo, 0);
            end
        end
        check("rev_done_busy", n_busy, 0);

        // Reverse back to fwd 30; hold a new command through the dead time
        cmd(1'b0, 30, 1'b0, 0);
        run_period();
        check("hold_p0_a1a", n_aa, 60);
        for (int k = 1; k <= 5; k++) begin
            run_period();
            check($sformatf("hold_dn_a1a_%0d", k), n_aa, 60 - 10 * k);
        end
        n_acc = 0;
        hold_valid = 1'b1;
        cmd(1'b0, 20, 1'b0, 10);
        run_period();
        check("hold_dead1_acc", n_acc, 0);
        check("hold_dead1_legs", n_aa + n_ab + n_ba + n_bb, 0);
        run_period();
        check("hold_dead2_acc", n_acc, 0);
        run_period();
        check("hold_run_acc", n_acc, 1);
        check("hold_run_a1b", n_ab, 10);
        check("hold_run_b1b", n_bb, 0);
        check("hold_run_rdy_lo", n_rdy_lo, 0);
        hold_valid = 1'b0;
        run_period();
        check("hold_r9_a1b", n_ab, 20);
        check("hold_r9_b1b", n_bb, 10);
        run_period();
        check("hold_r10_a1b", n_ab, 30);
        check("hold_r10_b1b", n_bb, 20);
        run_period();
        check("hold_r11_a1b", n_ab, 40);
        check("hold_r11_b1b", n_bb, 20);
        check("hold_r11_busy", n_busy, 0);
        check("hold_once_acc", n_acc, 1);

        // Duty 120 clamps to a full period
        cmd(1'b0, 120, 1'b0, 10);
        run_period();
        check("clamp_p0_a1b", n_ab, 40);
        for (int k = 1; k <= 14; k++) run_period();
        run_period();
        check("clamp_p15_a1b", n_ab, 190);
        run_period();
        check("clamp_full_a1b", n_ab, 200);
        check("clamp_full_b1b", n_bb, 20);
        check("clamp_full_busy", n_busy, 0);

        // Reset pulsed in the middle of a ramp-down
        cmd(1'b1, 50, 1'b0, 10);
        run_period();
        check("mid_p0_a1b", n_ab, 200);
        check("mid_p0_rdy_lo", n_rdy_lo, 199);
        run_period();
        check("mid_p1_a1b", n_ab, 190);
        run_period();
        check("mid_p2_a1b", n_ab, 180);
        clear_acc();
        run_cycles(50);
        check("mid_pre_rst_a1b", int'(A1_B), 1);
        rst_n = 1'b0;
        #1;
        check_in_reset("mid_rst_async");
        repeat (3) @(negedge clk);
        check_in_reset("mid_rst_held");
        rst_n = 1'b1;
        idle_periods("post_rst");

        // Command landing exactly on a period boundary takes that step
        clear_acc();
        run_cycles(199);
        cmd(1'b0, 10, 1'b0, 0);
        run_cycles(1);
        run_period();
        check("bnd_p1_a1b", n_ab, 10);
        check("bnd_p1_busy", n_busy, 200);
        run_period();
        check("bnd_p2_a1b", n_ab, 20);
        check("bnd_p2_busy", n_busy, 0);

        check("no_shoot_through", n_shoot, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/motor_ramp_ctrl.md
MOTOR_RAMP_CTRL -- requirements
Module: motor_ramp_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 10: clk cycles per PWM tick.
REQ-002 SHALL have parameter PWM_PERIOD, default 100: PWM ticks per PWM period.
REQ-003 SHALL have parameter RAMP_STEP, default 5: maximum duty change per PWM period.
REQ-004 SHALL have parameter DEAD_PERIODS, default 2: PWM periods with both legs low during a reversal.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port cmd_valid, input, 1 bit: command present.
REQ-008 SHALL have port cmd_ready, output, 1 bit: command can be accepted.
REQ-009 SHALL have ports cmd_dir_a and cmd_dir_b, input, 1 bit each: direction, 0 = forward, 1 = reverse.
REQ-010 SHALL have ports cmd_duty_a and cmd_duty_b, input, 7 bits each: target duty in ticks.
REQ-011 SHALL have ports A1_A and A1_B, output, 1 bit each: motor A H-bridge legs.
REQ-012 SHALL have ports B1_A and B1_B, output, 1 bit each: motor B H-bridge legs.
REQ-013 SHALL have port busy, output, 1 bit: a channel is ramping or reversing.

Function
REQ-014 SHALL generate one tick every CLK_DIV clk cycles from a free-running prescaler.
REQ-015 SHALL advance a shared tick counter 0..PWM_PERIOD-1 on each tick, wrapping to 0; wrap = period boundary.
REQ-016 SHALL drive each channel's PWM high while counter < current duty, giving 0 = always low and PWM_PERIOD = always high.
REQ-017 SHALL drive forward as A1_A=0, A1_B=pwm (B likewise) and reverse as A1_A=pwm, A1_B=0; both legs high SHALL never occur.
REQ-018 SHALL accept a command when cmd_valid and cmd_ready are both high on a clk edge, latching all four command fields.
REQ-019 SHALL clamp cmd_duty values above PWM_PERIOD to PWM_PERIOD.
REQ-020 SHALL run one independent FSM per channel, with states IDLE (duty 0), RUN, RAMPDOWN and DEAD.
REQ-021 On an accepted command with the same direction, or with current duty 0, the FSM SHALL take the new direction and target immediately and enter RUN (IDLE if target is 0).
REQ-022 On an accepted command with a changed direction and current duty > 0, the FSM SHALL enter RAMPDOWN, keep the old direction, and hold the new direction and target pending.
REQ-023 Duty SHALL change only at period boundaries; RUN moves it toward target by up to RAMP_STEP, saturating exactly at target.
REQ-024 RAMPDOWN SHALL decrease duty by RAMP_STEP per boundary, saturating at 0, then enter DEAD.
REQ-025 DEAD SHALL hold both legs low for DEAD_PERIODS full periods, then apply the pending direction and target and enter RUN.
REQ-026 cmd_ready SHALL be high only when neither channel is in RAMPDOWN or DEAD.
REQ-027 busy SHALL be high when any channel is in RAMPDOWN or DEAD, or its duty differs from its target.
REQ-028 A command that coincides with a period boundary SHALL apply its new target from that boundary's ramp step onward.

Reset
REQ-029 While rst_n is low, all H-bridge legs and busy SHALL be 0 and cmd_ready SHALL be 1.
REQ-030 While rst_n is low, prescaler, tick counter, duties and targets SHALL be 0, directions forward, and both FSMs IDLE.
REQ-031 Reset asserted mid-ramp or mid-reversal SHALL force all outputs low immediately, with no pending command retained.

Verification (defaults; 1 period = 1000 clk)
REQ-032 Release reset, no command -> all legs 0, cmd_ready=1, busy=0 for 5 periods.
REQ-033 Command A fwd 70, B fwd 0 -> A duty 5,10,...,70 over 14 boundaries; then A1_B high 700 of 1000 clk, A1_A=0, busy=0.
REQ-034 From A fwd 70, command A rev 30 -> cmd_ready=0; 14 ramp-down periods; 2 periods with A1_A=A1_B=0; 6 ramp-up periods; cmd_ready=1 on entering RUN, with A1_A high 300 clk per period.
REQ-035 Command duty 120 -> target clamped to 100; after ramp, leg held constantly high.
REQ-036 cmd_valid held with new values during DEAD -> not accepted until cmd_ready rises; the command is then accepted exactly once.
REQ-037 rst_n pulsed low mid-RAMPDOWN -> all legs 0 asynchronously; after release, behaviour matches REQ-032.
